// File: rtl/fileira_pkg.sv
// Shared definitions for enemy row controllers: row size, coordinate format
// and the march FSM state encoding.
package fileira_pkg;

    localparam int N_INIMIGOS = 5;
    localparam int COORD_W = 10;
    localparam logic [COORD_W-1:0] COORD_MORTO = 10'h3FF;

    typedef enum logic [1:0] {
        MARCHA,
        DESCE,
        PARADO
    } estado_fileira_t;

endpackage

// File: rtl/borda_fileira.sv
// Finds the leftmost and rightmost living enemies of the row; these decide
// when the formation touches a screen edge.
module borda_fileira
    import fileira_pkg::*;
(
    input  logic [N_INIMIGOS-1:0] vivos,
    output logic [2:0]            e,
    output logic [2:0]            d,
    output logic                  vazio
);

    // Two opposite priority encoders: the last match in each loop wins.
    always_comb begin
        e = 3'd0;
        d = 3'd0;
        vazio = (vivos == '0);
        for (int i = N_INIMIGOS - 1; i >= 0; i--) begin
            if (vivos[i]) e = 3'(i);
        end
        for (int i = 0; i < N_INIMIGOS; i++) begin
            if (vivos[i]) d = 3'(i);
        end
    end

endmodule

// File: rtl/controle_fileira.sv
// Marching controller for one row of enemies: steps sideways every few frames,
// drops and reverses at the edges, and parks dead enemies off-screen.
module controle_fileira
    import fileira_pkg::*;
#(
    parameter int X_INICIAL       = 80,
    parameter int Y_INICIAL       = 40,
    parameter int ESPACAMENTO     = 48,
    parameter int LARGURA_OBJETO  = 40,
    parameter int ALTURA_OBJETO   = 40,
    parameter int LARGURA_TELA    = 640,
    parameter int ALTURA_LIMITE   = 440,
    parameter int PASSO_X         = 4,
    parameter int PASSO_Y         = 16,
    parameter int DIVISOR_QUADROS = 4
)
(
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          TICK_QUADRO,
    input  logic                          ABATE_VALIDO,
    input  logic [2:0]                    ABATE_INDICE,
    output logic [N_INIMIGOS*COORD_W-1:0] X_OBJETO,
    output logic [N_INIMIGOS*COORD_W-1:0] Y_OBJETO,
    output logic [N_INIMIGOS-1:0]         VIVOS,
    output logic                          FILEIRA_LIMPA,
    output logic                          CHEGOU_FUNDO
);

    localparam int CNT_W  = $clog2(DIVISOR_QUADROS) + 1;
    localparam int CNT_W1 = CNT_W + 1;
    localparam logic [CNT_W:0] DIV_W = CNT_W1'(DIVISOR_QUADROS);
    localparam logic [COORD_W-1:0] X_INI_W = COORD_W'(X_INICIAL);
    localparam logic [COORD_W-1:0] Y_INI_W = COORD_W'(Y_INICIAL);
    localparam logic [COORD_W-1:0] PASSO_X_W = COORD_W'(PASSO_X);

    estado_fileira_t estado, estado_nxt;
    logic [COORD_W-1:0] base_x, base_x_nxt;
    logic [COORD_W-1:0] base_y, base_y_nxt;
    logic dir, dir_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W:0] cnt_inc;
    logic move_due;
    logic limpa_nxt, fundo_nxt;

    logic [N_INIMIGOS-1:0] mascara_abate, vivos_nxt;
    logic [2:0] idx_e, idx_d;
    logic vazio;
    logic [10:0] borda_dir, borda_esq, y_desce;
    logic bate_dir, bate_esq, chega_fundo;

    logic [N_INIMIGOS*COORD_W-1:0] x_nxt, y_nxt, x_ini;

    borda_fileira u_borda (
        .vivos (VIVOS),
        .e     (idx_e),
        .d     (idx_d),
        .vazio (vazio)
    );

    // Out-of-range indices produce an empty mask, so they are silently ignored.
    always_comb begin
        mascara_abate = '0;
        if (ABATE_VALIDO && (ABATE_INDICE < 3'(N_INIMIGOS))) mascara_abate[ABATE_INDICE] = 1'b1;
        vivos_nxt = VIVOS & ~mascara_abate;
    end

    // Edge tests look at the mask before this cycle's kill takes effect.
    assign borda_dir = 11'(base_x) + 11'(idx_d) * 11'(ESPACAMENTO) + 11'(LARGURA_OBJETO + PASSO_X);
    assign borda_esq = 11'(base_x) + 11'(idx_e) * 11'(ESPACAMENTO);
    assign bate_dir = borda_dir > 11'(LARGURA_TELA);
    assign bate_esq = borda_esq < 11'(PASSO_X);
    assign y_desce = 11'(base_y) + 11'(PASSO_Y);
    assign chega_fundo = (y_desce + 11'(ALTURA_OBJETO)) >= 11'(ALTURA_LIMITE);

    assign cnt_inc = {1'b0, cnt} + CNT_W1'(TICK_QUADRO);
    assign move_due = cnt_inc >= DIV_W;

    // A tick seen during the descent is banked in the counter, so the move it
    // owes happens on the first marching cycle afterwards.
    always_comb begin
        estado_nxt = estado;
        base_x_nxt = base_x;
        base_y_nxt = base_y;
        dir_nxt = dir;
        cnt_nxt = cnt;
        limpa_nxt = FILEIRA_LIMPA;
        fundo_nxt = CHEGOU_FUNDO;
        case (estado)
            MARCHA: begin
                cnt_nxt = move_due ? CNT_W'(cnt_inc - DIV_W) : cnt_inc[CNT_W-1:0];
                if (move_due && !vazio) begin
                    if ((!dir && bate_dir) || (dir && bate_esq)) begin
                        estado_nxt = DESCE;
                    end else if (!dir) begin
                        base_x_nxt = base_x + PASSO_X_W;
                    end else begin
                        base_x_nxt = base_x - PASSO_X_W;
                    end
                end
            end
            DESCE: begin
                if (TICK_QUADRO && ({1'b0, cnt} < DIV_W)) cnt_nxt = cnt + CNT_W'(1);
                base_y_nxt = y_desce[COORD_W-1:0];
                dir_nxt = ~dir;
                if (chega_fundo) begin
                    fundo_nxt = 1'b1;
                    estado_nxt = PARADO;
                end else begin
                    estado_nxt = MARCHA;
                end
            end
            default: begin
            end
        endcase
        // The last kill wins over any move or descent decided this cycle.
        if (vivos_nxt == '0) begin
            limpa_nxt = 1'b1;
            estado_nxt = PARADO;
            base_x_nxt = base_x;
            base_y_nxt = base_y;
            dir_nxt = dir;
            fundo_nxt = CHEGOU_FUNDO;
        end
    end

    for (genvar i = 0; i < N_INIMIGOS; i++) begin : g_pack
        assign x_nxt[COORD_W*i +: COORD_W] = vivos_nxt[i] ? base_x_nxt + COORD_W'(i * ESPACAMENTO) : COORD_MORTO;
        assign y_nxt[COORD_W*i +: COORD_W] = vivos_nxt[i] ? base_y_nxt : COORD_MORTO;
        assign x_ini[COORD_W*i +: COORD_W] = X_INI_W + COORD_W'(i * ESPACAMENTO);
    end

    // Outputs are loaded from next-state values so moves and kills show up one
    // edge after the request.
    always_ff @(posedge CLK) begin
        if (reset) begin
            estado <= MARCHA;
            base_x <= X_INI_W;
            base_y <= Y_INI_W;
            dir <= 1'b0;
            cnt <= '0;
            VIVOS <= '1;
            FILEIRA_LIMPA <= 1'b0;
            CHEGOU_FUNDO <= 1'b0;
            X_OBJETO <= x_ini;
            Y_OBJETO <= {N_INIMIGOS{Y_INI_W}};
        end else begin
            estado <= estado_nxt;
            base_x <= base_x_nxt;
            base_y <= base_y_nxt;
            dir <= dir_nxt;
            cnt <= cnt_nxt;
            VIVOS <= vivos_nxt;
            FILEIRA_LIMPA <= limpa_nxt;
            CHEGOU_FUNDO <= fundo_nxt;
            X_OBJETO <= x_nxt;
            Y_OBJETO <= y_nxt;
        end
    end

endmodule

// File: tb/tb_controle_fileira.sv
// Directed bench for the enemy row controller: three instances share the
// stimulus (divider 1, low starting row, divider 4).
module tb_controle_fileira;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    logic TICK_QUADRO = 1'b0;
    logic ABATE_VALIDO = 1'b0;
    logic [2:0] ABATE_INDICE = 3'd0;

    logic [49:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic [4:0] vivos_a, vivos_b, vivos_c;
    logic limpa_a, limpa_b, limpa_c, fundo_a, fundo_b, fundo_c;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    controle_fileira #(.DIVISOR_QUADROS(1)) dut_a (
        .CLK(CLK), .reset(reset), .TICK_QUADRO(TICK_QUADRO),
        .ABATE_VALIDO(ABATE_VALIDO), .ABATE_INDICE(ABATE_INDICE),
        .X_OBJETO(x_a), .Y_OBJETO(y_a), .VIVOS(vivos_a),
        .FILEIRA_LIMPA(limpa_a), .CHEGOU_FUNDO(fundo_a)
    );

    controle_fileira #(.DIVISOR_QUADROS(1), .Y_INICIAL(392)) dut_b (
        .CLK(CLK), .reset(reset), .TICK_QUADRO(TICK_QUADRO),
        .ABATE_VALIDO(ABATE_VALIDO), .ABATE_INDICE(ABATE_INDICE),
        .X_OBJETO(x_b), .Y_OBJETO(y_b), .VIVOS(vivos_b),
        .FILEIRA_LIMPA(limpa_b), .CHEGOU_FUNDO(fundo_b)
    );

    controle_fileira #(.DIVISOR_QUADROS(4)) dut_c (
        .CLK(CLK), .reset(reset), .TICK_QUADRO(TICK_QUADRO),
        .ABATE_VALIDO(ABATE_VALIDO), .ABATE_INDICE(ABATE_INDICE),
        .X_OBJETO(x_c), .Y_OBJETO(y_c), .VIVOS(vivos_c),
        .FILEIRA_LIMPA(limpa_c), .CHEGOU_FUNDO(fundo_c)
    );

    function automatic logic [9:0] fx(input logic [49:0] bus, input int i);
        return bus[10*i +: 10];
    endfunction

    // One-cycle pulse, ending on the falling edge after the sampling edge.
    task automatic applyStimulus(input logic t, input logic kv, input logic [2:0] ki);
        @(negedge CLK);
        TICK_QUADRO = t;
        ABATE_VALIDO = kv;
        ABATE_INDICE = ki;
        @(negedge CLK);
        TICK_QUADRO = 1'b0;
        ABATE_VALIDO = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp_x;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_x = 10'(80 + 48 * i);
            checks++;
            if (fx(x_a, i) !== exp_x) begin
                errors++;
                $display("[TB] FAIL reset_x%0d got=%0d exp=%0d", i, fx(x_a, i), exp_x);
            end
            checks++;
            if (fx(y_a, i) !== 10'd40) begin
                errors++;
                $display("[TB] FAIL reset_y%0d got=%0d exp=40", i, fx(y_a, i));
            end
        end
        checks++;
        if (vivos_a !== 5'b11111 || limpa_a !== 1'b0 || fundo_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags vivos=%b limpa=%b fundo=%b exp 11111/0/0", vivos_a, limpa_a, fundo_a);
        end
        checks++;
        if (fx(y_b, 0) !== 10'd392 || fundo_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_low_row y0=%0d fundo=%b exp 392/0", fx(y_b, 0), fundo_b);
        end
    endtask

    task automatic test_right_edge();
        do_reset();
        ticks(82);
        checks++;
        if (fx(x_a, 0) !== 10'd408 || fx(y_a, 0) !== 10'd40) begin
            errors++;
            $display("[TB] FAIL edge_before x0=%0d y0=%0d exp 408/40", fx(x_a, 0), fx(y_a, 0));
        end
        ticks(1);
        checks++;
        if (fx(y_a, 0) !== 10'd40) begin
            errors++;
            $display("[TB] FAIL edge_lat1 y0=%0d exp 40", fx(y_a, 0));
        end
        @(negedge CLK);
        checks++;
        if (fx(y_a, 0) !== 10'd56 || fx(x_a, 0) !== 10'd408 || fx(y_a, 4) !== 10'd56) begin
            errors++;
            $display("[TB] FAIL edge_descent x0=%0d y0=%0d y4=%0d exp 408/56/56", fx(x_a, 0), fx(y_a, 0), fx(y_a, 4));
        end
        ticks(1);
        checks++;
        if (fx(x_a, 0) !== 10'd404 || fx(y_a, 0) !== 10'd56) begin
            errors++;
            $display("[TB] FAIL edge_reverse x0=%0d y0=%0d exp 404/56", fx(x_a, 0), fx(y_a, 0));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ticks(82);
        @(negedge CLK);
        TICK_QUADRO = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        TICK_QUADRO = 1'b0;
        checks++;
        if (fx(y_a, 0) !== 10'd56 || fx(x_a, 0) !== 10'd408) begin
            errors++;
            $display("[TB] FAIL b2b_descent x0=%0d y0=%0d exp 408/56", fx(x_a, 0), fx(y_a, 0));
        end
        @(negedge CLK);
        checks++;
        if (fx(x_a, 0) !== 10'd404) begin
            errors++;
            $display("[TB] FAIL b2b_banked_tick x0=%0d exp 404", fx(x_a, 0));
        end
    endtask

    task automatic test_kill();
        do_reset();
        applyStimulus(1'b0, 1'b1, 3'd4);
        checks++;
        if (vivos_a !== 5'b01111 || fx(x_a, 4) !== 10'h3FF || fx(y_a, 4) !== 10'h3FF || fx(x_a, 0) !== 10'd80) begin
            errors++;
            $display("[TB] FAIL kill4 vivos=%b x4=%h y4=%h x0=%0d exp 01111/3ff/3ff/80", vivos_a, fx(x_a, 4), fx(y_a, 4), fx(x_a, 0));
        end
        applyStimulus(1'b0, 1'b1, 3'd4);
        applyStimulus(1'b0, 1'b1, 3'd6);
        checks++;
        if (vivos_a !== 5'b01111 || fx(x_a, 3) !== 10'd224 || fx(y_a, 3) !== 10'd40) begin
            errors++;
            $display("[TB] FAIL kill_noop vivos=%b x3=%0d y3=%0d exp 01111/224/40", vivos_a, fx(x_a, 3), fx(y_a, 3));
        end
        ticks(94);
        checks++;
        if (fx(x_a, 0) !== 10'd456 || fx(y_a, 0) !== 10'd40) begin
            errors++;
            $display("[TB] FAIL kill_march x0=%0d y0=%0d exp 456/40", fx(x_a, 0), fx(y_a, 0));
        end
        ticks(1);
        @(negedge CLK);
        checks++;
        if (fx(x_a, 0) !== 10'd456 || fx(y_a, 0) !== 10'd56 || fx(x_a, 4) !== 10'h3FF) begin
            errors++;
            $display("[TB] FAIL kill_descent x0=%0d y0=%0d x4=%h exp 456/56/3ff", fx(x_a, 0), fx(y_a, 0), fx(x_a, 4));
        end
    endtask

    task automatic test_clear();
        do_reset();
        @(negedge CLK);
        ABATE_VALIDO = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ABATE_INDICE = 3'(i);
            @(negedge CLK);
            if (i == 3) begin
                checks++;
                if (vivos_a !== 5'b10000 || limpa_a !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL clear_fourth vivos=%b limpa=%b exp 10000/0", vivos_a, limpa_a);
                end
            end
        end
        ABATE_VALIDO = 1'b0;
        checks++;
        if (vivos_a !== 5'b00000 || limpa_a !== 1'b1 || x_a !== {50{1'b1}} || y_a !== {50{1'b1}}) begin
            errors++;
            $display("[TB] FAIL clear_fifth vivos=%b limpa=%b x=%h y=%h", vivos_a, limpa_a, x_a, y_a);
        end
        ticks(3);
        checks++;
        if (limpa_a !== 1'b1 || x_a !== {50{1'b1}} || fundo_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_sticky limpa=%b fundo=%b x=%h exp 1/0/all ones", limpa_a, fundo_a, x_a);
        end
    endtask

    task automatic test_bottom();
        do_reset();
        ticks(83);
        @(negedge CLK);
        checks++;
        if (fx(y_b, 0) !== 10'd408 || fundo_b !== 1'b1 || fx(x_b, 0) !== 10'd408) begin
            errors++;
            $display("[TB] FAIL bottom_land x0=%0d y0=%0d fundo=%b exp 408/408/1", fx(x_b, 0), fx(y_b, 0), fundo_b);
        end
        ticks(5);
        checks++;
        if (fx(x_b, 0) !== 10'd408 || fx(y_b, 2) !== 10'd408 || fundo_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bottom_frozen x0=%0d y2=%0d fundo=%b exp 408/408/1", fx(x_b, 0), fx(y_b, 2), fundo_b);
        end
        checks++;
        if (fundo_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bottom_high_row fundo=%b exp 0", fundo_a);
        end
    endtask

    task automatic test_divider();
        do_reset();
        ticks(3);
        checks++;
        if (fx(x_c, 0) !== 10'd80) begin
            errors++;
            $display("[TB] FAIL div_hold x0=%0d exp 80", fx(x_c, 0));
        end
        ticks(1);
        checks++;
        if (fx(x_c, 0) !== 10'd84) begin
            errors++;
            $display("[TB] FAIL div_first x0=%0d exp 84", fx(x_c, 0));
        end
        ticks(4);
        checks++;
        if (fx(x_c, 0) !== 10'd88 || fx(x_c, 1) !== 10'd136) begin
            errors++;
            $display("[TB] FAIL div_second x0=%0d x1=%0d exp 88/136", fx(x_c, 0), fx(x_c, 1));
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ticks(82);
        applyStimulus(1'b1, 1'b1, 3'd4);
        checks++;
        if (vivos_a !== 5'b01111 || fx(x_a, 4) !== 10'h3FF || fx(x_a, 0) !== 10'd408) begin
            errors++;
            $display("[TB] FAIL simul_kill vivos=%b x4=%h x0=%0d exp 01111/3ff/408", vivos_a, fx(x_a, 4), fx(x_a, 0));
        end
        @(negedge CLK);
        checks++;
        if (fx(y_a, 0) !== 10'd56 || fx(y_a, 4) !== 10'h3FF) begin
            errors++;
            $display("[TB] FAIL simul_descent y0=%0d y4=%h exp 56/3ff", fx(y_a, 0), fx(y_a, 4));
        end
        ticks(1);
        checks++;
        if (fx(x_a, 0) !== 10'd404) begin
            errors++;
            $display("[TB] FAIL simul_reverse x0=%0d exp 404", fx(x_a, 0));
        end
    endtask

    initial begin
        test_reset();
        test_right_edge();
        test_back_to_back();
        test_kill();
        test_clear();
        test_bottom();
        test_divider();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controle_fileira.md
# controle_fileira

Sequential position controller for one row of five enemy sprites (space-invaders-style march). Once every `DIVISOR_QUADROS` frames it steps the row horizontally. At a screen edge it steps down and reverses. It tracks which enemies are alive and drives the packed `X_OBJETO`/`Y_OBJETO` buses consumed directly by the row sprite renderer. Dead enemies are parked off-screen so the renderer never draws them.

## Interface
- `X_INICIAL`, 80: reset x of enemy 0.
- `Y_INICIAL`, 40: reset y of the row.
- `ESPACAMENTO`, 48: x pitch between consecutive enemies.
- `LARGURA_OBJETO`, 40: sprite width used for right-edge test.
- `ALTURA_OBJETO`, 40: sprite height used for bottom test.
- `LARGURA_TELA`, 640: visible width.
- `ALTURA_LIMITE`, 440: y at which the row has "landed".
- `PASSO_X`, 4: horizontal step per move.
- `PASSO_Y`, 16: vertical step per descent.
- `DIVISOR_QUADROS`, 4: frame ticks per move (≥1).
- `CLK`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `TICK_QUADRO`  in  1  one-cycle pulse per frame, issued during vertical blank.
- `ABATE_VALIDO`  in  1  one-cycle request to kill an enemy.
- `ABATE_INDICE`  in  3  enemy index to kill (0–4); values 5–7 ignored.
- `X_OBJETO`  out  50  packed x; enemy i in bits [10i+9:10i].
- `Y_OBJETO`  out  50  packed y, same layout.
- `VIVOS`  out  5  alive mask, bit i = enemy i.
- `FILEIRA_LIMPA`  out  1  level: all enemies dead.
- `CHEGOU_FUNDO`  out  1  level: row reached `ALTURA_LIMITE`.

## Operation
- State: `base_x`, `base_y` (10-bit), `dir` (0 = right, 1 = left), `VIVOS`, and a frame counter of `$clog2(DIVISOR_QUADROS)+1` bits.
- FSM has three states:
  - `MARCHA`: normal running state.
  - `DESCE`: one cycle, pending vertical step.
  - `PARADO`: terminal; holds until reset.
- Alive enemy i: x = `base_x` + i·`ESPACAMENTO` and y = `base_y`. Dead enemy i: both fields are 10'h3FF.
- All outputs are registered. Compare arithmetic uses 11 bits, with no wrap.
- In `MARCHA`, each `TICK_QUADRO` increments the counter. When the counter reaches `DIVISOR_QUADROS`, it clears and a move is evaluated. `e` = leftmost alive index and `d` = rightmost alive index:
  - If `dir`=0 and `base_x` + d·`ESPACAMENTO` + `LARGURA_OBJETO` + `PASSO_X` > `LARGURA_TELA`: go to `DESCE`.
  - Else if `dir`=1 and `base_x` + e·`ESPACAMENTO` < `PASSO_X`: go to `DESCE`.
  - Otherwise `base_x` ± `PASSO_X`.
- `DESCE` does the following, then returns to `MARCHA`:
  - `base_y` += `PASSO_Y`; `dir` toggles; `base_x` unchanged.
  - If the new `base_y` + `ALTURA_OBJETO` ≥ `ALTURA_LIMITE`: set `CHEGOU_FUNDO` and enter `PARADO` instead.
- Kill handling:
  - `ABATE_VALIDO` with a valid index clears that `VIVOS` bit.
  - Killing an already-dead enemy has no effect.
  - Kills are accepted in every state.
- When `VIVOS` becomes 0: set `FILEIRA_LIMPA` and enter `PARADO`. Flags are sticky until reset.
- In `PARADO`, positions freeze, except that newly killed enemies still park at 3FF.

## Timing
- Reset values:
  - `base_x`=`X_INICIAL`, `base_y`=`Y_INICIAL`, `dir`=0, counter=0, state `MARCHA`.
  - `VIVOS`=5'b11111, both flags 0.
  - Outputs show the initial formation on the first cycle after reset.
- Horizontal move: outputs change on the clock edge after the triggering `TICK_QUADRO` (latency 1).
- Descent: outputs change 2 cycles after the triggering tick. Both land well inside vertical blank.
- Kill latency is 1 cycle, for both the `VIVOS` bit and the X/Y fields going to 3FF.
- Kill and move evaluated in the same cycle:
  - The edge test uses the pre-kill mask.
  - The new mask applies from the next evaluation onward.
- Last kill: `FILEIRA_LIMPA` rises in the same cycle as the last `VIVOS` bit clears. That kill cancels any pending move or descent.
- `TICK_QUADRO` during `DESCE` is counted but cannot trigger a second move. A tick is never lost.
- `reset` mid-operation overrides everything on that edge.

## Structure
- Shared package `fileira_pkg` holds:
  - `N_INIMIGOS`=5, `COORD_W`=10, `COORD_MORTO`=10'h3FF.
  - The FSM state enum, also used by future row controllers.
- Sub-module `borda_fileira`: combinational; from `VIVOS` it yields `e`, `d` (3-bit) and `vazio`. It is a priority encoder in both directions.
- Top level: FSM, counters, and a generate loop packing the five X/Y fields.

## Test plan
All scenarios use `DIVISOR_QUADROS`=1 unless noted.
- Reset:
  - Stimulus: hold `reset`, then release.
  - Required: X fields = 80, 128, 176, 224, 272; all Y fields = 40; `VIVOS`=11111; flags 0.
- Right edge:
  - Stimulus: 82 ticks.
  - Required: enemy 0 x=408.
  - Stimulus: the 83rd tick.
  - Required: Y=56, X unchanged, `dir`=1 two cycles after the tick.
  - Stimulus: the next tick.
  - Required: enemy 0 x=404.
- Kill:
  - Stimulus: kill index 4, then march right.
  - Required: field 4 = 3FF/3FF one cycle after the request. Descent occurs only after enemy 0 x=456.
  - Stimulus: kill index 4 again, or index 6.
  - Required: no change.
- Clear:
  - Stimulus: kill indices 0–4 on consecutive cycles.
  - Required: `FILEIRA_LIMPA`=1 on the edge of the fifth kill; all fields 3FF; later ticks cause no movement.
- Bottom:
  - Stimulus: `Y_INICIAL`=392; force a descent.
  - Required: Y=408, `CHEGOU_FUNDO`=1; positions frozen thereafter.
- Divider and simultaneity:
  - Stimulus: `DIVISOR_QUADROS`=4.
  - Required: x advances once per 4 ticks.
  - Stimulus: kill index 4 on the same cycle as an edge-triggering tick.
  - Required: descent still happens.
